// File: rtl/wm_pkg.sv
// Shared washing-machine types and defaults: supervisor state encoding and the
// timeout/threshold values also used by the main controller.
package wm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        ERROR = 3'd4
    } wm_state_e;

    localparam int DEF_LEVEL_W       = 10;
    localparam int DEF_FILL_TIMEOUT  = 20;
    localparam int DEF_DRAIN_TIMEOUT = 20;
    localparam int DEF_MAX_RETRIES   = 2;
    localparam int DEF_LEAK_HYST     = 16;
    localparam int DEF_LEAK_CYCLES   = 4;

    // One spare bit above the largest terminal count so saturation never aliases.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/level_timeout_monitor_phase_timer.sv
// Loadable, saturating cycle counter with clear, enable and terminal-count flag.
module phase_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == term);

endmodule

// File: rtl/level_timeout_monitor.sv
// Fill/drain supervisor: drives valve and pump against the level sensor, retries
// timed-out phases, watches for leaks while holding water, latches sticky errors.
module level_timeout_monitor
    import wm_pkg::*;
#(
    parameter int LEVEL_W       = DEF_LEVEL_W,
    parameter int FILL_TIMEOUT  = DEF_FILL_TIMEOUT,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int LEAK_HYST     = DEF_LEAK_HYST,
    parameter int LEAK_CYCLES   = DEF_LEAK_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fill_req,
    input  logic               drain_req,
    input  logic               abort,
    input  logic               err_clear,
    input  logic [LEVEL_W-1:0] level,
    input  logic [LEVEL_W-1:0] fill_target,
    input  logic [LEVEL_W-1:0] empty_level,
    output logic               valve_en,
    output logic               pump_en,
    output logic               fill_done,
    output logic               drain_done,
    output logic               water_flow_error,
    output logic               drainage_error,
    output logic [2:0]         retry_count,
    output logic               busy
);

    localparam int CNT_W  = cnt_width(FILL_TIMEOUT, DRAIN_TIMEOUT);
    localparam int LEAK_W = $clog2(LEAK_CYCLES + 1) + 1;

    localparam logic [CNT_W-1:0]   FILL_TERM  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   DRAIN_TERM = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [LEAK_W-1:0]  LEAK_TERM  = LEAK_W'(LEAK_CYCLES - 1);
    localparam logic [2:0]         MAX_RETRY  = 3'(MAX_RETRIES);
    localparam logic [LEVEL_W:0]   HYST_EXT   = (LEVEL_W + 1)'(LEAK_HYST);

    wm_state_e  state_d, state_q;
    logic [2:0] retry_d, retry_q;
    logic       wfe_d, wfe_q;
    logic       de_d, de_q;
    logic       fill_done_d, fill_done_q;
    logic       drain_done_d, drain_done_q;
    logic       valve_d, valve_q;
    logic       pump_d, pump_q;
    logic       busy_d, busy_q;

    logic               tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0]   tmr_term;
    logic               leak_clr, leak_en, leak_tc;
    logic [LEVEL_W:0]   hyst_diff;
    logic [LEVEL_W-1:0] leak_thr;
    logic               below_leak, fill_ok, drain_ok, leak_hit;

    // Threshold logic is unsigned; a target below the hysteresis floors at 0,
    // which makes "level < 0" impossible and so disables leak detection.
    assign hyst_diff  = {1'b0, fill_target} - HYST_EXT;
    assign leak_thr   = hyst_diff[LEVEL_W] ? '0 : hyst_diff[LEVEL_W-1:0];
    assign below_leak = (level < leak_thr);
    assign fill_ok    = (level >= fill_target);
    assign drain_ok   = (level <= empty_level);
    assign leak_hit   = below_leak && leak_tc;

    assign tmr_term = (state_q == DRAIN) ? DRAIN_TERM : FILL_TERM;
    assign leak_en  = (state_q == HOLD) && below_leak;
    assign leak_clr = !leak_en;

    phase_timer #(.W(CNT_W)) u_phase_tmr (
        .clk      (clk),
        .reset    (reset),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .term     (tmr_term),
        .tc       (tmr_tc)
    );

    phase_timer #(.W(LEAK_W)) u_leak_tmr (
        .clk      (clk),
        .reset    (reset),
        .clr      (leak_clr),
        .en       (leak_en),
        .load     (1'b0),
        .load_val ({LEAK_W{1'b0}}),
        .term     (LEAK_TERM),
        .tc       (leak_tc)
    );

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        wfe_d        = wfe_q;
        de_d         = de_q;
        fill_done_d  = 1'b0;
        drain_done_d = 1'b0;
        tmr_clr      = 1'b1;
        tmr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!abort) begin
                    if (drain_req) begin
                        state_d = DRAIN;
                        retry_d = '0;
                    end else if (fill_req) begin
                        state_d = FILL;
                        retry_d = '0;
                    end
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (fill_ok) begin
                    state_d     = HOLD;
                    fill_done_d = 1'b1;
                end else if (tmr_tc) begin
                    if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 3'd1;
                    end else begin
                        state_d = ERROR;
                        wfe_d   = 1'b1;
                    end
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (drain_req) begin
                    state_d = DRAIN;
                    retry_d = '0;
                end else if (leak_hit) begin
                    state_d = ERROR;
                    wfe_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (drain_ok) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end else if (tmr_tc) begin
                    if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 3'd1;
                    end else begin
                        state_d = ERROR;
                        de_d    = 1'b1;
                    end
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            ERROR: begin
                if (err_clear) begin
                    state_d = IDLE;
                    wfe_d   = 1'b0;
                    de_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        valve_d = (state_d == FILL);
        pump_d  = (state_d == DRAIN);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            retry_q      <= '0;
            wfe_q        <= 1'b0;
            de_q         <= 1'b0;
            fill_done_q  <= 1'b0;
            drain_done_q <= 1'b0;
            valve_q      <= 1'b0;
            pump_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            wfe_q        <= wfe_d;
            de_q         <= de_d;
            fill_done_q  <= fill_done_d;
            drain_done_q <= drain_done_d;
            valve_q      <= valve_d;
            pump_q       <= pump_d;
            busy_q       <= busy_d;
        end
    end

    assign valve_en         = valve_q;
    assign pump_en          = pump_q;
    assign fill_done        = fill_done_q;
    assign drain_done       = drain_done_q;
    assign water_flow_error = wfe_q;
    assign drainage_error   = de_q;
    assign retry_count      = retry_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_level_timeout_monitor.sv
// Directed bench for level_timeout_monitor with default parameters.
module tb_level_timeout_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       fill_req, drain_req, abort, err_clear;
    logic [9:0] level, fill_target, empty_level;
    logic       valve_en, pump_en, fill_done, drain_done;
    logic       water_flow_error, drainage_error, busy;
    logic [2:0] retry_count;
    logic [9:0] outs;

    int total = 0;
    int bad   = 0;

    level_timeout_monitor dut (
        .clk              (clk),
        .reset            (reset),
        .fill_req         (fill_req),
        .drain_req        (drain_req),
        .abort            (abort),
        .err_clear        (err_clear),
        .level            (level),
        .fill_target      (fill_target),
        .empty_level      (empty_level),
        .valve_en         (valve_en),
        .pump_en          (pump_en),
        .fill_done        (fill_done),
        .drain_done       (drain_done),
        .water_flow_error (water_flow_error),
        .drainage_error   (drainage_error),
        .retry_count      (retry_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    assign outs = {valve_en, pump_en, fill_done, drain_done, water_flow_error,
                   drainage_error, retry_count, busy};

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; fill_req = 1'b0; drain_req = 1'b0; abort = 1'b0; err_clear = 1'b0;
        level = 10'd0; fill_target = 10'd300; empty_level = 10'd10;
        tick(2);
        chkv("reset_outs", outs, 10'b0);

        // Fill success
        reset = 1'b1; fill_req = 1'b1;
        tick(1);
        chk1("fill_valve_on", valve_en, 1'b1);
        chk1("fill_busy", busy, 1'b1);
        fill_req = 1'b0;
        tick(2);
        level = 10'd200;
        tick(3);
        chk1("fill_no_done_yet", fill_done, 1'b0);
        chk1("fill_valve_still", valve_en, 1'b1);
        level = 10'd300;
        tick(1);
        chk1("fill_done_pulse", fill_done, 1'b1);
        chk1("fill_valve_off", valve_en, 1'b0);
        tick(1);
        chk1("fill_done_once", fill_done, 1'b0);
        chk1("hold_busy", busy, 1'b1);
        chk1("hold_no_err", water_flow_error, 1'b0);

        // Within hysteresis: no leak
        level = 10'd290;
        tick(50);
        chk1("hyst_no_err", water_flow_error, 1'b0);
        chk1("hyst_still_hold", busy, 1'b1);

        // Leak: 250 < 284 for four cycles
        level = 10'd250;
        tick(3);
        chk1("leak_3cyc_no_err", water_flow_error, 1'b0);
        tick(1);
        chk1("leak_err", water_flow_error, 1'b1);
        chk1("leak_valve_off", valve_en, 1'b0);
        fill_req = 1'b1; drain_req = 1'b1;
        tick(2);
        chk1("err_ignore_pump", pump_en, 1'b0);
        chk1("err_ignore_valve", valve_en, 1'b0);
        chk1("err_sticky", water_flow_error, 1'b1);
        fill_req = 1'b0; drain_req = 1'b0; err_clear = 1'b1;
        tick(1);
        chkv("err_clear_outs", outs, 10'b0);
        err_clear = 1'b0;

        // Fill retries then error
        level = 10'd0; fill_req = 1'b1;
        tick(1);
        chk3("retry_start", retry_count, 3'd0);
        fill_req = 1'b0;
        tick(19);
        chk3("retry_c19", retry_count, 3'd0);
        tick(1);
        chk3("retry_c20", retry_count, 3'd1);
        chk1("retry_valve_on", valve_en, 1'b1);
        tick(20);
        chk3("retry_c40", retry_count, 3'd2);
        tick(19);
        chk1("retry_c59_no_err", water_flow_error, 1'b0);
        tick(1);
        chk1("retry_c60_err", water_flow_error, 1'b1);
        chk1("retry_c60_valve", valve_en, 1'b0);
        chk1("retry_c60_busy", busy, 1'b1);
        err_clear = 1'b1;
        tick(1);
        chk1("retry_clear_busy", busy, 1'b0);
        chk1("retry_clear_flag", water_flow_error, 1'b0);
        err_clear = 1'b0;

        // Success on the timeout cycle wins over retry
        fill_req = 1'b1;
        tick(1);
        chk3("tc_entry_retry0", retry_count, 3'd0);
        fill_req = 1'b0;
        tick(19);
        level = 10'd300;
        tick(1);
        chk1("tc_fill_done", fill_done, 1'b1);
        chk3("tc_no_retry", retry_count, 3'd0);
        tick(1);
        chk1("tc_hold", busy, 1'b1);

        // Drain from HOLD
        drain_req = 1'b1;
        tick(1);
        chk1("drain_pump_on", pump_en, 1'b1);
        drain_req = 1'b0;
        tick(7);
        chk1("drain_no_done_yet", drain_done, 1'b0);
        level = 10'd5;
        tick(1);
        chk1("drain_done_pulse", drain_done, 1'b1);
        chk1("drain_pump_off", pump_en, 1'b0);
        chk1("drain_idle", busy, 1'b0);
        tick(1);
        chk1("drain_done_once", drain_done, 1'b0);

        // Drain exhaustion
        level = 10'd300; drain_req = 1'b1;
        tick(1);
        drain_req = 1'b0;
        tick(59);
        chk1("dex_c59_pump", pump_en, 1'b1);
        chk3("dex_c59_retry", retry_count, 3'd2);
        chk1("dex_c59_no_err", drainage_error, 1'b0);
        tick(1);
        chk1("dex_err", drainage_error, 1'b1);
        chk1("dex_pump_off", pump_en, 1'b0);
        chk1("dex_no_wfe", water_flow_error, 1'b0);

        // Reset glitch between edges has no effect
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick(1);
        chk1("glitch_no_effect", drainage_error, 1'b1);
        reset = 1'b0;
        tick(1);
        chkv("reset_in_error", outs, 10'b0);
        reset = 1'b1;

        // Both requests: drain wins; then reset mid-drain
        fill_req = 1'b1; drain_req = 1'b1;
        tick(1);
        chk1("prio_pump", pump_en, 1'b1);
        chk1("prio_valve", valve_en, 1'b0);
        fill_req = 1'b0; drain_req = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        chkv("reset_in_drain", outs, 10'b0);
        reset = 1'b1;

        // Abort mid-fill
        level = 10'd0; fill_req = 1'b1;
        tick(1);
        fill_req = 1'b0;
        tick(4);
        abort = 1'b1;
        tick(1);
        chk1("abort_valve_off", valve_en, 1'b0);
        chk1("abort_idle", busy, 1'b0);
        chk1("abort_no_done", fill_done, 1'b0);
        abort = 1'b0; fill_req = 1'b1;
        tick(1);
        chk1("abort_refill_valve", valve_en, 1'b1);
        chk3("abort_refill_retry", retry_count, 3'd0);
        fill_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
